// File: rtl/m_window_3x3_gen.sv
// Raster-to-window generator: buffers two image lines and emits a registered
// 3x3 neighbourhood for every interior centre pixel of the frame.
module m_window_3x3_gen #(
    parameter int pWidth  = 64,
    parameter int pHeight = 64,
    localparam int cColW  = $clog2(pWidth),
    localparam int cRowW  = $clog2(pHeight)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    input  logic             iSof,
    input  logic [7:0]       iv8Pixel,
    output logic [7:0]       ov8Pixel_a,
    output logic [7:0]       ov8Pixel_b,
    output logic [7:0]       ov8Pixel_c,
    output logic [7:0]       ov8Pixel_d,
    output logic [7:0]       ov8Pixel_fij,
    output logic [7:0]       ov8Pixel_e,
    output logic [7:0]       ov8Pixel_f,
    output logic [7:0]       ov8Pixel_g,
    output logic [7:0]       ov8Pixel_h,
    output logic             oDataValid,
    output logic [cRowW-1:0] ovRow,
    output logic [cColW-1:0] ovCol,
    output logic             oFrameDone
);

    logic [cRowW-1:0]     rowIn;
    logic [cRowW-1:0]     rowCur;
    logic [cColW-1:0]     colIn;
    logic [cColW-1:0]     colCur;
    logic                 lastCol;
    logic                 lastRow;
    logic                 emit;

    // line1 holds the previous row, line2 the row before that; never reset,
    // emission gating keeps stale contents from ever reaching the outputs
    logic [7:0]           line1 [pWidth];
    logic [7:0]           line2 [pWidth];
    logic [7:0]           rdLine1;
    logic [7:0]           rdLine2;

    // window indexed [row][col], row 0 = top, col 0 = left
    logic [2:0][2:0][7:0] win;
    logic [2:0][2:0][7:0] winNext;
    logic [2:0][2:0][7:0] winOut;

    // a start-of-frame pixel is always (0,0), whatever the counters say
    assign rowCur  = iSof ? '0 : rowIn;
    assign colCur  = iSof ? '0 : colIn;
    assign lastCol = (colCur == cColW'(pWidth - 1));
    assign lastRow = (rowCur == cRowW'(pHeight - 1));
    assign emit    = iValid && (rowCur >= cRowW'(2)) && (colCur >= cColW'(2));

    assign rdLine1 = line1[colCur];
    assign rdLine2 = line2[colCur];

    assign ov8Pixel_a   = winOut[0][0];
    assign ov8Pixel_b   = winOut[0][1];
    assign ov8Pixel_c   = winOut[0][2];
    assign ov8Pixel_d   = winOut[1][0];
    assign ov8Pixel_fij = winOut[1][1];
    assign ov8Pixel_e   = winOut[1][2];
    assign ov8Pixel_f   = winOut[2][0];
    assign ov8Pixel_g   = winOut[2][1];
    assign ov8Pixel_h   = winOut[2][2];

    // shift the window one column left and load the incoming column on the right
    always_comb begin
        winNext = win;
        for (int r = 0; r < 3; r++) begin
            winNext[r][0] = win[r][1];
            winNext[r][1] = win[r][2];
        end
        winNext[0][2] = rdLine2;
        winNext[1][2] = rdLine1;
        winNext[2][2] = iv8Pixel;
    end

    // raster position of the next expected pixel
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rowIn <= '0;
            colIn <= '0;
        end else if (iValid) begin
            if (lastCol) begin
                colIn <= '0;
                rowIn <= lastRow ? '0 : rowCur + 1'b1;
            end else begin
                colIn <= colCur + 1'b1;
                rowIn <= rowCur;
            end
        end
    end

    // window shift register and registered outputs (data holds between strobes)
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            win        <= '0;
            winOut     <= '0;
            ovRow      <= '0;
            ovCol      <= '0;
            oDataValid <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            oDataValid <= emit;
            oFrameDone <= iValid && lastRow && lastCol;
            if (iValid) begin
                win <= winNext;
            end
            if (emit) begin
                winOut <= winNext;
                ovRow  <= rowCur - 1'b1;
                ovCol  <= colCur - 1'b1;
            end
        end
    end

    // line buffers: read-before-write at the same column address
    always_ff @(posedge iClk) begin
        if (iValid) begin
            line2[colCur] <= line1[colCur];
            line1[colCur] <= iv8Pixel;
        end
    end

endmodule

// File: tb/tb_m_window_3x3_gen.sv
// Self-checking bench for m_window_3x3_gen: an image-array reference model
// predicts every output each cycle; literal checks pin the model on known frames.
module tb_m_window_3x3_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic       iClk     = 1'b0;
    logic       iRst_n   = 1'b1;
    logic       iValid   = 1'b0;
    logic       iSof     = 1'b0;
    logic [7:0] iv8Pixel = 8'd0;

    logic [7:0] ov8Pixel_a, ov8Pixel_b, ov8Pixel_c;
    logic [7:0] ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e;
    logic [7:0] ov8Pixel_f, ov8Pixel_g, ov8Pixel_h;
    logic       oDataValid;
    logic       oFrameDone;
    logic [$clog2(H)-1:0] ovRow;
    logic [$clog2(W)-1:0] ovCol;

    m_window_3x3_gen #(.pWidth(W), .pHeight(H)) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iValid      (iValid),
        .iSof        (iSof),
        .iv8Pixel    (iv8Pixel),
        .ov8Pixel_a  (ov8Pixel_a),
        .ov8Pixel_b  (ov8Pixel_b),
        .ov8Pixel_c  (ov8Pixel_c),
        .ov8Pixel_d  (ov8Pixel_d),
        .ov8Pixel_fij(ov8Pixel_fij),
        .ov8Pixel_e  (ov8Pixel_e),
        .ov8Pixel_f  (ov8Pixel_f),
        .ov8Pixel_g  (ov8Pixel_g),
        .ov8Pixel_h  (ov8Pixel_h),
        .oDataValid  (oDataValid),
        .ovRow       (ovRow),
        .ovCol       (ovCol),
        .oFrameDone  (oFrameDone)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;
    int doneCnt  = 0;

    typedef struct {
        int               row;
        int               col;
        logic [8:0][7:0]  px;
    } win_t;
    win_t winLog[$];
    win_t refLog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // reference model: whole-image array filled by raster position
    logic [7:0] img [H][W];
    logic [7:0] expWin [9];
    logic       expValid = 1'b0;
    logic       expDone  = 1'b0;
    int         expRow = 0, expCol = 0;
    int         nextR = 0, nextC = 0;
    int         mr, mc;

    initial for (int k = 0; k < 9; k++) expWin[k] = 8'd0;

    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            nextR = 0; nextC = 0;
            expValid = 1'b0; expDone = 1'b0;
            expRow = 0; expCol = 0;
            for (int k = 0; k < 9; k++) expWin[k] = 8'd0;
        end else begin
            expValid = 1'b0;
            expDone  = 1'b0;
            if (iValid) begin
                mr = iSof ? 0 : nextR;
                mc = iSof ? 0 : nextC;
                img[mr][mc] = iv8Pixel;
                if (mr >= 2 && mc >= 2) begin
                    expValid = 1'b1;
                    for (int k = 0; k < 9; k++) expWin[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
                    expRow = mr - 1;
                    expCol = mc - 1;
                end
                expDone = (mr == H - 1) && (mc == W - 1);
                nextC = (mc + 1) % W;
                nextR = (mc == W - 1) ? (mr + 1) % H : mr;
            end
        end
    end

    // compare every cycle on the falling edge; also record emitted windows
    initial begin
        logic [7:0] dout [9];
        win_t       w;
        forever begin
            @(negedge iClk);
            dout[0] = ov8Pixel_a;   dout[1] = ov8Pixel_b;   dout[2] = ov8Pixel_c;
            dout[3] = ov8Pixel_d;   dout[4] = ov8Pixel_fij; dout[5] = ov8Pixel_e;
            dout[6] = ov8Pixel_f;   dout[7] = ov8Pixel_g;   dout[8] = ov8Pixel_h;
            chk("oDataValid", oDataValid, expValid);
            chk("oFrameDone", oFrameDone, expDone);
            chk("ovRow", ovRow, expRow);
            chk("ovCol", ovCol, expCol);
            for (int k = 0; k < 9; k++) chk($sformatf("pix%0d", k), dout[k], expWin[k]);
            if (oDataValid) begin
                w.row = ovRow;
                w.col = ovCol;
                for (int k = 0; k < 9; k++) w.px[k] = dout[k];
                winLog.push_back(w);
            end
            if (oFrameDone) doneCnt++;
        end
    end

    task automatic drive(input logic [7:0] p, input logic s, input int gapMax);
        iValid   = 1'b1;
        iSof     = s;
        iv8Pixel = p;
        @(negedge iClk);
        iValid = 1'b0;
        iSof   = 1'b0;
        if (gapMax > 0) repeat ($urandom_range(gapMax, 0)) @(negedge iClk);
    endtask

    task automatic sendRows(input int offs, input int gapMax, input int nPix);
        for (int n = 0; n < nPix; n++)
            drive(8'((n / W) * 10 + (n % W) + offs), n == 0, gapMax);
    endtask

    task automatic flush();
        iValid = 1'b0;
        repeat (4) @(negedge iClk);
    endtask

    task automatic clearLog();
        winLog.delete();
        doneCnt = 0;
    endtask

    initial begin
        #1 iRst_n = 1'b0;
        repeat (3) @(negedge iClk);
        #2 iRst_n = 1'b1;
        @(negedge iClk);

        // reset asserted while a window is being presented
        clearLog();
        sendRows(0, 0, 2 * W + 3);
        chk("pre_reset_valid", oDataValid, 1);
        #2 iRst_n = 1'b0;
        #1;
        chk("rst_valid", oDataValid, 0);
        chk("rst_done", oFrameDone, 0);
        chk("rst_row", ovRow, 0);
        chk("rst_col", ovCol, 0);
        chk("rst_fij", ov8Pixel_fij, 0);
        chk("rst_a", ov8Pixel_a, 0);
        chk("rst_h", ov8Pixel_h, 0);
        repeat (2) @(negedge iClk);
        #2 iRst_n = 1'b1;
        @(negedge iClk);

        // one frame, continuous valid
        clearLog();
        sendRows(0, 0, W * H);
        flush();
        chk("f1_windows", winLog.size(), 6);
        chk("f1_done", doneCnt, 1);
        if (winLog.size() == 6) begin
            chk("f1_first_a",   winLog[0].px[0], 0);
            chk("f1_first_b",   winLog[0].px[1], 1);
            chk("f1_first_c",   winLog[0].px[2], 2);
            chk("f1_first_d",   winLog[0].px[3], 10);
            chk("f1_first_fij", winLog[0].px[4], 11);
            chk("f1_first_e",   winLog[0].px[5], 12);
            chk("f1_first_f",   winLog[0].px[6], 20);
            chk("f1_first_g",   winLog[0].px[7], 21);
            chk("f1_first_h",   winLog[0].px[8], 22);
            chk("f1_first_row", winLog[0].row, 1);
            chk("f1_first_col", winLog[0].col, 1);
            chk("f1_last_fij",  winLog[5].px[4], 23);
            chk("f1_last_row",  winLog[5].row, 2);
            chk("f1_last_col",  winLog[5].col, 3);
        end
        refLog = winLog;

        // same frame with random gaps
        clearLog();
        sendRows(0, 3, W * H);
        flush();
        chk("gap_windows", winLog.size(), 6);
        chk("gap_done", doneCnt, 1);
        if (winLog.size() == 6 && refLog.size() == 6)
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("gap_win%0d_px", i), (winLog[i].px == refLog[i].px), 1);
                chk($sformatf("gap_win%0d_pos", i), winLog[i].row * 16 + winLog[i].col,
                    refLog[i].row * 16 + refLog[i].col);
            end

        // two back-to-back frames
        clearLog();
        sendRows(0, 0, W * H);
        sendRows(100, 0, W * H);
        flush();
        chk("b2b_windows", winLog.size(), 12);
        chk("b2b_done", doneCnt, 2);
        if (winLog.size() == 12) begin
            chk("b2b_f2_fij", winLog[6].px[4], 111);
            for (int k = 0; k < 9; k++)
                chk($sformatf("b2b_f2_px%0d_new", k), winLog[6].px[k] >= 8'd100, 1);
        end

        // frame aborted by iSof at (2,3), then a full frame
        clearLog();
        sendRows(0, 0, 2 * W + 3);
        sendRows(50, 0, W * H);
        flush();
        chk("abort_windows", winLog.size(), 7);
        chk("abort_done", doneCnt, 1);
        if (winLog.size() == 7) begin
            chk("abort_old_fij", winLog[0].px[4], 11);
            chk("abort_old_pos", winLog[0].row * 16 + winLog[0].col, 17);
            chk("abort_new_fij", winLog[1].px[4], 61);
            chk("abort_new_pos", winLog[1].row * 16 + winLog[1].col, 17);
            chk("abort_last_fij", winLog[6].px[4], 73);
        end

        // random data, random gaps, occasional start-of-frame anywhere
        for (int n = 0; n < 200; n++)
            drive(8'($urandom), ($urandom_range(24, 0) == 0), 2);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
